fd_multi_div: RTL and testbench

- Parametrised multi-channel frequency divider: the successor to the team's single fixed-ratio 50 MHz divider.
- Each channel produces a one-cycle tick strobe and a 50 %-duty square wave, both derived from the shared system clock.
- Each channel has a runtime-programmable divisor and its own enable.
- Feeds game-logic update rates, paddle/ball movement timing, display refresh and the sound tone generator.

---
 rtl/fd_pkg.sv | 19 +
 rtl/fd_channel.sv | 80 ++++++++
 rtl/fd_multi_div.sv | 47 ++++
 tb/tb_fd_multi_div.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared constants for the multi-channel frequency divider: system clock rate
// and the standard divisors used by game logic, display and sound.
package fd_pkg;

    localparam int unsigned CLK_HZ    = 50_000_000;

    localparam int unsigned DIV_100HZ = 250_000;
    localparam int unsigned DIV_1KHZ  = 25_000;
    localparam int unsigned DIV_10KHZ = 2_500;

    // Divisor giving a square wave of f Hz (two wraps per sq period).
    function automatic int unsigned hz_to_div(input int unsigned f);
        if (f == 0) begin
            return 0;
        end
        return CLK_HZ / (2 * f);
    endfunction

endpackage

// File: rtl/fd_channel.sv
// One divider channel: phase counter, active/shadow divisor pair and the
// registered tick/sq/busy outputs.
module fd_channel
    import fd_pkg::*;
#(
    parameter int CNT_W       = 25,
    parameter int DIV_DEFAULT = DIV_100HZ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] eff_div;
    logic             wrap;

    // A stored divisor of zero behaves like one.
    always_comb begin
        eff_div = (active == '0) ? CNT_W'(1) : active;
        wrap    = (cnt == eff_div - CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= DIV_INIT;
            shadow <= DIV_INIT;
            tick   <= 1'b0;
            sq     <= 1'b0;
            busy   <= 1'b0;
        end else if (sync_clr) begin
            cnt    <= '0;
            tick   <= 1'b0;
            sq     <= 1'b0;
            busy   <= 1'b0;
            active <= wr ? wr_val : shadow;
            if (wr) begin
                shadow <= wr_val;
            end
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (wrap) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    sq   <= ~sq;
                    // Pending divisor only takes over at a period boundary.
                    if (busy) begin
                        active <= shadow;
                        busy   <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A write in the wrap cycle stays pending for the next wrap.
            if (wr) begin
                shadow <= wr_val;
                if (en) begin
                    busy <= 1'b1;
                end else begin
                    active <= wr_val;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fd_multi_div.sv
// Multi-channel frequency divider top: decodes divisor writes to per-channel
// strobes and fans out the shared clear to every channel.
module fd_multi_div
    import fd_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 25,
    parameter int DIV_DEFAULT = DIV_100HZ,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] ch_wr;

    // Channel indices past NUM_CH match no strobe, so such writes vanish.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign ch_wr[i] = div_wr && (div_ch == CH_W'(i));

            fd_channel #(
                .CNT_W      (CNT_W),
                .DIV_DEFAULT(DIV_DEFAULT)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en[i]),
                .sync_clr(sync_clr),
                .wr      (ch_wr[i]),
                .wr_val  (div_val),
                .tick    (tick[i]),
                .sq      (sq[i]),
                .busy    (busy[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fd_multi_div.sv
// Scoreboard bench for fd_multi_div: directed stimulus pushes expected tick
// events, a negedge monitor pops and compares whenever any tick is high.
module tb_fd_multi_div;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 25;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NUM_CH-1:0] en = '0;
    logic              sync_clr = 1'b0;
    logic              div_wr = 1'b0;
    logic [CH_W-1:0]   div_ch = '0;
    logic [CNT_W-1:0]  div_val = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] busy;

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] tick;
        logic [3:0] sq;
        logic [3:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    fd_multi_div #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DIV_DEFAULT(5),
        .CH_W       (CH_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync_clr(sync_clr),
        .div_wr  (div_wr),
        .div_ch  (div_ch),
        .div_val (div_val),
        .tick    (tick),
        .sq      (sq),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Cycle n is the state right after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with any tick high must match the next expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (tick != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_tick: cycle=%0d tick=%b sq=%b busy=%b, expected no tick",
                             cyc, tick, sq, busy);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.tick != tick || e.sq != sq || e.busy != busy) begin
                        failures++;
                        $display("[TB] FAIL %s: got cycle=%0d tick=%b sq=%b busy=%b, expected cycle=%0d tick=%b sq=%b busy=%b",
                                 e.name, cyc, tick, sq, busy, e.cyc, e.tick, e.sq, e.busy);
                    end
                end
            end
        end
    end

    task automatic pushExp(input string name, input int c, input logic [3:0] t,
                           input logic [3:0] s, input logic [3:0] b);
        exp_t e;
        e.name = name;
        e.cyc  = c;
        e.tick = t;
        e.sq   = s;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] e, input logic wr, input logic [1:0] ch,
                                 input logic [24:0] val, input logic clr, input int n);
        en       = e;
        div_wr   = wr;
        div_ch   = ch;
        div_val  = val;
        sync_clr = clr;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        en       = '0;
        div_wr   = 1'b0;
        sync_clr = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] t,
                               input logic [3:0] s, input logic [3:0] b);
        checks++;
        if (tick != t || sq != s || busy != b) begin
            failures++;
            $display("[TB] FAIL %s: got tick=%b sq=%b busy=%b, expected tick=%b sq=%b busy=%b",
                     name, tick, sq, busy, t, s, b);
        end
    endtask

    task automatic checkDrained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_missing_ticks: got %0d expected events left over, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int p;
        int q;

        // Default divisor 5 on channel 0 only.
        applyReset();
        checkOutput("reset_state", 4'b0000, 4'b0000, 4'b0000);
        p = cyc;
        pushExp("t1_tick_a", p + 5,  4'b0001, 4'b0001, 4'b0000);
        pushExp("t1_tick_b", p + 10, 4'b0001, 4'b0000, 4'b0000);
        pushExp("t1_tick_c", p + 15, 4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 16);
        checkOutput("t1_after", 4'b0000, 4'b0001, 4'b0000);
        checkDrained("t1");

        // Write 3 to running ch0 at cnt=1: old period finishes, then D=3.
        applyReset();
        p = cyc;
        pushExp("t2_old_wrap", p + 5,  4'b0001, 4'b0001, 4'b0000);
        pushExp("t2_new_a",    p + 8,  4'b0001, 4'b0000, 4'b0000);
        pushExp("t2_new_b",    p + 11, 4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 1);
        applyStimulus(4'b0001, 1'b1, 2'd0, 25'd3, 1'b0, 1);
        checkOutput("t2_busy_set", 4'b0000, 4'b0000, 4'b0001);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 2);
        checkOutput("t2_busy_held", 4'b0000, 4'b0000, 4'b0001);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 8);
        checkOutput("t2_after", 4'b0000, 4'b0001, 4'b0000);
        checkDrained("t2");

        // Divisors 0 and then 1 on disabled ch1: both tick every cycle.
        applyReset();
        p = cyc;
        applyStimulus(4'b0000, 1'b1, 2'd1, 25'd0, 1'b0, 1);
        checkOutput("t3_div0_no_busy", 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            pushExp("t3_div0", p + 2 + k, 4'b0010, (k % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0000);
        end
        applyStimulus(4'b0010, 1'b0, 2'd0, 25'd0, 1'b0, 6);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25'd0, 1'b0, 1);
        checkOutput("t3_hold", 4'b0000, 4'b0000, 4'b0000);
        q = cyc;
        applyStimulus(4'b0000, 1'b1, 2'd1, 25'd1, 1'b0, 1);
        for (int k = 0; k < 6; k++) begin
            pushExp("t3_div1", q + 2 + k, 4'b0010, (k % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0000);
        end
        applyStimulus(4'b0010, 1'b0, 2'd0, 25'd0, 1'b0, 6);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25'd0, 1'b0, 1);
        checkDrained("t3");

        // Pause ch0 at cnt=2 for 7 cycles: phase and sq are held.
        applyReset();
        p = cyc;
        pushExp("t4_first",  p + 5,  4'b0001, 4'b0001, 4'b0000);
        pushExp("t4_resume", p + 17, 4'b0001, 4'b0000, 4'b0000);
        pushExp("t4_next",   p + 22, 4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 7);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25'd0, 1'b0, 3);
        checkOutput("t4_paused", 4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25'd0, 1'b0, 4);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 8);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25'd0, 1'b0, 1);
        checkDrained("t4");

        // ch0 D=4, ch2 D=6, pending 6 on ch0; sync_clr realigns both to D=6.
        applyReset();
        applyStimulus(4'b0000, 1'b1, 2'd0, 25'd4, 1'b0, 1);
        applyStimulus(4'b0000, 1'b1, 2'd2, 25'd6, 1'b0, 1);
        p = cyc;
        pushExp("t5_pre", p + 4, 4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0101, 1'b0, 2'd0, 25'd0, 1'b0, 4);
        applyStimulus(4'b0101, 1'b1, 2'd0, 25'd6, 1'b0, 1);
        checkOutput("t5_pending", 4'b0000, 4'b0001, 4'b0001);
        applyStimulus(4'b0101, 1'b0, 2'd0, 25'd0, 1'b1, 1);
        checkOutput("t5_cleared", 4'b0000, 4'b0000, 4'b0000);
        pushExp("t5_aligned_a", p + 12, 4'b0101, 4'b0101, 4'b0000);
        pushExp("t5_aligned_b", p + 18, 4'b0101, 4'b0000, 4'b0000);
        applyStimulus(4'b0101, 1'b0, 2'd0, 25'd0, 1'b0, 12);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25'd0, 1'b0, 1);
        checkDrained("t5");

        // Async reset mid-period with a pending write: write is lost.
        applyReset();
        p = cyc;
        pushExp("t6_first", p + 5, 4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 6);
        applyStimulus(4'b0001, 1'b1, 2'd0, 25'd2, 1'b0, 1);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 1);
        checkOutput("t6_pending", 4'b0000, 4'b0001, 4'b0001);
        en    = '0;
        rst_n = 1'b0;
        #2;
        checkOutput("t6_async_reset", 4'b0000, 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q = cyc;
        pushExp("t6_default_div", q + 5, 4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 2'd0, 25'd0, 1'b0, 6);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25'd0, 1'b0, 1);
        checkDrained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
